// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: tracks E/M/W destination slots and produces
// stall, flush and per-source forwarding selects plus saturating event counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_D,
  input  logic [NUM_SRC*REG_AW-1:0]   rs_D,
  input  logic [REG_AW-1:0]           rd_D,
  input  logic                        regwrite_D,
  input  logic                        load_D,
  input  logic                        PCSrcE,
  input  logic                        ex_busy,
  input  logic                        clr_cnt,
  output logic                        StallF,
  output logic                        StallD,
  output logic                        FlushD,
  output logic                        FlushE,
  output logic [NUM_SRC*2-1:0]        Forward_E,
  output logic [CNT_W-1:0]            stall_cnt,
  output logic [CNT_W-1:0]            flush_cnt
);

  typedef enum logic [1:0] {
    ACT_NORMAL,
    ACT_BUSY,
    ACT_BRANCH,
    ACT_LOAD_USE
  } action_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Slot registers
  logic                        e_v_reg, e_rw_reg, e_ld_reg;
  logic [REG_AW-1:0]           e_rd_reg;
  logic [NUM_SRC*REG_AW-1:0]   e_rs_reg;
  logic                        m_v_reg, m_rw_reg, m_ld_reg;
  logic [REG_AW-1:0]           m_rd_reg;
  logic                        w_v_reg, w_rw_reg;
  logic [REG_AW-1:0]           w_rd_reg;
  logic [CNT_W-1:0]            stall_cnt_reg, flush_cnt_reg;

  logic [NUM_SRC-1:0]          src_hit;
  logic                        load_use;
  action_t                     action;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src_hit
      assign src_hit[gi] = (rs_D[gi*REG_AW +: REG_AW] == e_rd_reg);
    end
  endgenerate

  assign load_use = e_v_reg & e_ld_reg & (e_rd_reg != '0) & valid_D & (|src_hit);

  always_comb begin
    action = ACT_NORMAL;
    if (ex_busy)
      action = ACT_BUSY;
    else if (PCSrcE && e_v_reg)
      action = ACT_BRANCH;
    else if (load_use)
      action = ACT_LOAD_USE;
  end

  // Reset is held low as a whole-pipeline override, so control outputs are quiet then too.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (reset) begin
      case (action)
        ACT_BUSY: begin
          StallF = 1'b1;
          StallD = 1'b1;
        end
        ACT_BRANCH: begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end
        ACT_LOAD_USE: begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A load sitting in M never forwards; the load-use stall routes it through W instead.
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
      logic [REG_AW-1:0] src;
      logic              m_hit, w_hit;
      assign src   = e_rs_reg[gi*REG_AW +: REG_AW];
      assign m_hit = m_v_reg & m_rw_reg & (m_rd_reg == src) & (src != '0) & ~m_ld_reg;
      assign w_hit = w_v_reg & w_rw_reg & (w_rd_reg == src) & (src != '0);
      always_comb begin
        Forward_E[gi*2 +: 2] = 2'b00;
        if (e_v_reg) begin
          if (m_hit)
            Forward_E[gi*2 +: 2] = 2'b10;
          else if (w_hit)
            Forward_E[gi*2 +: 2] = 2'b01;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_v_reg  <= 1'b0;
      e_rw_reg <= 1'b0;
      e_ld_reg <= 1'b0;
      e_rd_reg <= '0;
      e_rs_reg <= '0;
      m_v_reg  <= 1'b0;
      m_rw_reg <= 1'b0;
      m_ld_reg <= 1'b0;
      m_rd_reg <= '0;
      w_v_reg  <= 1'b0;
      w_rw_reg <= 1'b0;
      w_rd_reg <= '0;
    end else begin
      w_v_reg  <= m_v_reg;
      w_rw_reg <= m_rw_reg;
      w_rd_reg <= m_rd_reg;
      case (action)
        ACT_BUSY: begin
          m_v_reg <= 1'b0;
        end
        ACT_BRANCH, ACT_LOAD_USE: begin
          m_v_reg  <= e_v_reg;
          m_rw_reg <= e_rw_reg;
          m_ld_reg <= e_ld_reg;
          m_rd_reg <= e_rd_reg;
          e_v_reg  <= 1'b0;
        end
        default: begin
          m_v_reg  <= e_v_reg;
          m_rw_reg <= e_rw_reg;
          m_ld_reg <= e_ld_reg;
          m_rd_reg <= e_rd_reg;
          e_v_reg  <= valid_D;
          e_rw_reg <= regwrite_D;
          e_ld_reg <= load_D;
          e_rd_reg <= rd_D;
          e_rs_reg <= rs_D;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clr_cnt) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (StallD && (stall_cnt_reg != CNT_MAX))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if ((action == ACT_BRANCH) && (flush_cnt_reg != CNT_MAX))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic, checked
// against a shift-array pipeline model; a CNT_W=2 twin exercises saturation.
module tb_pipe_hazard_ctrl;

  localparam int NS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, valid_D, regwrite_D, load_D, PCSrcE, ex_busy, clr_cnt;
  logic [9:0] rs_D;
  logic [4:0] rd_D;

  logic        StallF, StallD, FlushD, FlushE;
  logic [3:0]  Forward_E;
  logic [15:0] stall_cnt, flush_cnt;
  logic        StallF_s, StallD_s, FlushD_s, FlushE_s;
  logic [3:0]  Forward_E_s;
  logic [1:0]  stall_cnt_s, flush_cnt_s;

  pipe_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .valid_D(valid_D), .rs_D(rs_D), .rd_D(rd_D),
    .regwrite_D(regwrite_D), .load_D(load_D), .PCSrcE(PCSrcE), .ex_busy(ex_busy),
    .clr_cnt(clr_cnt), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .Forward_E(Forward_E), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .valid_D(valid_D), .rs_D(rs_D), .rd_D(rd_D),
    .regwrite_D(regwrite_D), .load_D(load_D), .PCSrcE(PCSrcE), .ex_busy(ex_busy),
    .clr_cnt(clr_cnt), .StallF(StallF_s), .StallD(StallD_s), .FlushD(FlushD_s),
    .FlushE(FlushE_s), .Forward_E(Forward_E_s), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  // Model: pipe[0]=E, pipe[1]=M, pipe[2]=W
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit ld;
    int rs0;
    int rs1;
  } slot_t;

  slot_t pipe [3];
  slot_t decode_slot;
  int    cnt_stall, cnt_flush, cnt_stall_s, cnt_flush_s;
  int    kind;          // 0 normal, 1 busy, 2 branch, 3 load-use
  bit    cur_rst_n, cur_clr;
  int    checks = 0;
  int    errors = 0;

  function automatic bit writes_reg(slot_t s, int r);
    return s.v && s.rw && (s.rd == r) && (r != 0);
  endfunction

  function automatic int fwd_code(int src);
    if (!pipe[0].v || src == 0) return 0;
    if (writes_reg(pipe[1], src) && !pipe[1].ld) return 2;
    if (writes_reg(pipe[2], src)) return 1;
    return 0;
  endfunction

  function automatic int sat_inc(int v, int max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one decode-stage cycle and compare all outputs against the model.
  task automatic apply(input bit rst_n, input bit v, input int rs0, input int rs1,
                       input int rd, input bit rw, input bit ld,
                       input bit pc, input bit busy, input bit clr);
    bit luse;
    bit e_sf, e_sd, e_fd, e_fe;
    logic [3:0] e_fwd;
    int f0, f1;
    reset      = rst_n;
    valid_D    = v;
    rs_D       = {rs1[4:0], rs0[4:0]};
    rd_D       = rd[4:0];
    regwrite_D = rw;
    load_D     = ld;
    PCSrcE     = pc;
    ex_busy    = busy;
    clr_cnt    = clr;
    decode_slot = '{v: v, rd: rd, rw: rw, ld: ld, rs0: rs0, rs1: rs1};
    cur_rst_n = rst_n;
    cur_clr   = clr;
    #1;
    luse = pipe[0].v && pipe[0].ld && pipe[0].rd != 0 && v &&
           (rs0 == pipe[0].rd || rs1 == pipe[0].rd);
    if (busy)                kind = 1;
    else if (pc && pipe[0].v) kind = 2;
    else if (luse)           kind = 3;
    else                     kind = 0;
    e_sf = rst_n && (kind == 1 || kind == 3);
    e_sd = e_sf;
    e_fd = rst_n && (kind == 2);
    e_fe = rst_n && (kind == 2 || kind == 3);
    f0 = fwd_code(pipe[0].rs0);
    f1 = fwd_code(pipe[0].rs1);
    e_fwd = {f1[1:0], f0[1:0]};
    check("StallF", 32'(StallF), 32'(e_sf));
    check("StallD", 32'(StallD), 32'(e_sd));
    check("FlushD", 32'(FlushD), 32'(e_fd));
    check("FlushE", 32'(FlushE), 32'(e_fe));
    check("Forward_E", 32'(Forward_E), 32'(e_fwd));
    check("stall_cnt", 32'(stall_cnt), 32'(cnt_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(cnt_flush));
    check("StallD_sat", 32'(StallD_s), 32'(e_sd));
    check("stall_cnt_sat", 32'(stall_cnt_s), 32'(cnt_stall_s));
    check("flush_cnt_sat", 32'(flush_cnt_s), 32'(cnt_flush_s));
  endtask

  task automatic nop(input bit clr);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, clr);
  endtask

  // Clock edge: advance the model by the decision taken in the last apply.
  task automatic tick();
    slot_t bubble;
    bubble = '{v: 0, rd: 0, rw: 0, ld: 0, rs0: 0, rs1: 0};
    @(posedge clk);
    if (!cur_rst_n) begin
      for (int i = 0; i < 3; i++) pipe[i] = bubble;
      cnt_stall = 0; cnt_flush = 0; cnt_stall_s = 0; cnt_flush_s = 0;
    end else begin
      if (cur_clr) begin
        cnt_stall = 0; cnt_flush = 0; cnt_stall_s = 0; cnt_flush_s = 0;
      end else begin
        if (kind == 1 || kind == 3) begin
          cnt_stall   = sat_inc(cnt_stall, 65535);
          cnt_stall_s = sat_inc(cnt_stall_s, 3);
        end
        if (kind == 2) begin
          cnt_flush   = sat_inc(cnt_flush, 65535);
          cnt_flush_s = sat_inc(cnt_flush_s, 3);
        end
      end
      pipe[2] = pipe[1];
      if (kind == 1) begin
        pipe[1] = bubble;
      end else begin
        pipe[1] = pipe[0];
        pipe[0] = (kind == 0) ? decode_slot : bubble;
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '{v: 0, rd: 0, rw: 0, ld: 0, rs0: 0, rs1: 0};
    cnt_stall = 0; cnt_flush = 0; cnt_stall_s = 0; cnt_flush_s = 0;
    kind = 0; cur_rst_n = 0; cur_clr = 0;
    reset = 0; valid_D = 0; rs_D = '0; rd_D = '0; regwrite_D = 0; load_D = 0;
    PCSrcE = 0; ex_busy = 0; clr_cnt = 0;
    @(posedge clk);
    #1;

    // Reset with random inputs, then idle
    for (int i = 0; i < 2; i++) begin
      apply(0, 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      check("rst_StallD", 32'(StallD), 32'd0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      nop(0);
      check("idle_stall_cnt", 32'(stall_cnt), 32'd0);
      tick();
    end

    // Forwarding: MEM path, WB path, x0 producer
    apply(1, 1, 0, 0, 5, 1, 0, 0, 0, 0); tick();
    apply(1, 1, 5, 5, 6, 1, 0, 0, 0, 0); tick();
    nop(0); check("fwd_mem", 32'(Forward_E), 32'b1010); tick();
    apply(1, 1, 0, 0, 9, 1, 0, 0, 0, 0); tick();
    apply(1, 1, 0, 0, 10, 1, 0, 0, 0, 0); tick();
    apply(1, 1, 9, 9, 12, 1, 0, 0, 0, 0); tick();
    nop(0); check("fwd_wb", 32'(Forward_E), 32'b0101); tick();
    apply(1, 1, 0, 0, 0, 1, 0, 0, 0, 0); tick();
    apply(1, 1, 0, 0, 13, 1, 0, 0, 0, 0); tick();
    nop(0); check("fwd_x0", 32'(Forward_E), 32'b0000); tick();

    // Load-use: one stall, then WB forwarding for source 1
    apply(1, 1, 0, 0, 7, 1, 1, 0, 0, 0); tick();
    apply(1, 1, 3, 7, 8, 1, 0, 0, 0, 0);
    check("lu_StallF", 32'(StallF), 32'd1);
    check("lu_FlushE", 32'(FlushE), 32'd1);
    tick();
    apply(1, 1, 3, 7, 8, 1, 0, 0, 0, 0);
    check("lu_released", 32'(StallD), 32'd0);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    tick();
    nop(0); check("lu_fwd", 32'(Forward_E), 32'b0100); tick();

    // Branch taken while a load-use condition also holds
    apply(1, 1, 0, 0, 4, 1, 1, 0, 0, 0); tick();
    apply(1, 1, 4, 4, 14, 1, 0, 1, 0, 0);
    check("br_FlushD", 32'(FlushD), 32'd1);
    check("br_StallD", 32'(StallD), 32'd0);
    tick();
    nop(0);
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(stall_cnt), 32'd1);
    tick();

    // Multi-cycle EX overriding a branch, then the branch after it finishes
    nop(1); tick();
    apply(1, 1, 0, 0, 11, 1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      apply(1, 1, 11, 2, 15, 1, 0, 1, 1, 0);
      check("busy_StallF", 32'(StallF), 32'd1);
      check("busy_FlushD", 32'(FlushD), 32'd0);
      tick();
    end
    apply(1, 1, 11, 2, 15, 1, 0, 1, 0, 0);
    check("busy_stall_cnt", 32'(stall_cnt), 32'd4);
    check("busy_then_flush", 32'(FlushE), 32'd1);
    tick();

    // Saturation on the 2-bit twin, clear during a stall, reset during a stall
    nop(1); tick();
    for (int i = 0; i < 5; i++) begin
      apply(1, 1, 0, 0, 7, 1, 1, 0, 0, 0); tick();
      apply(1, 1, 7, 1, 8, 1, 0, 0, 0, 0); tick();
      apply(1, 1, 7, 1, 8, 1, 0, 0, 0, 0); tick();
    end
    nop(0);
    check("sat_stall_cnt", 32'(stall_cnt_s), 32'd3);
    check("wide_stall_cnt", 32'(stall_cnt), 32'd5);
    tick();
    apply(1, 1, 0, 0, 7, 1, 1, 0, 0, 0); tick();
    apply(1, 1, 7, 1, 8, 1, 0, 0, 0, 1);
    check("clr_stall_seen", 32'(StallD), 32'd1);
    tick();
    nop(0); check("clr_wins", 32'(stall_cnt_s), 32'd0); tick();
    apply(1, 1, 0, 0, 7, 1, 1, 0, 0, 0); tick();
    apply(1, 1, 7, 7, 8, 1, 0, 0, 0, 0); tick();
    apply(1, 1, 0, 0, 7, 1, 1, 0, 0, 0); tick();
    apply(0, 1, 7, 7, 8, 1, 0, 0, 1, 0); tick();
    nop(0);
    check("rst_mid_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_mid_stall_fwd", 32'(Forward_E), 32'd0);
    tick();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 3) != 0),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 31) == 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
